spi_xfer_seq: RTL and testbench
===============================

// Module: spi_xfer_seq
// PURPOSE
//  Transfer sequencer for the SPI core datapath.
//  - Generates SCK from a programmable divider and honours CPOL/CPHA.
//  - Counts bits per word and words per transfer.
//  - Issues load/shift/sample strobes to the shift register.
//  - Owns chip-select timing, busy/last status and the word-level TX/RX handshakes.
//  - Sits between the register/FIFO front-end and the shift-register/pad logic.
// PARAMETERS
//  DIV_WIDTH  16  width of clock divider; SCK half-period = div_i+1 clk_i cycles
//  TRL_WIDTH  16  width of transfer-length field
// PORTS
//  clk_i       in   1          system clock
//  rst_n_i     in   1          asynchronous reset, active-low
//  en_i        in   1          core enable; low aborts any transfer
//  start_i     in   1          start pulse, accepted only in IDLE with en_i=1
//  div_i       in   DIV_WIDTH  SCK half-period minus 1
//  cpol_i      in   1          SCK idle level
//  cpha_i      in   1          0: sample leading edge, 1: sample trailing edge
//  mode_i      in   2          00 std (1 bit/edge), 01 dual (2), 10 quad (4), 11 = std
//  trl_i       in   TRL_WIDTH  words per transfer minus 1
//  tx_valid_i  in   1          TX word available
//  tx_ready_o  out  1          TX word accepted (handshake with tx_valid_i)
//  rx_valid_o  out  1          RX word complete in shifter
//  rx_ready_i  in   1          RX word consumed
//  load_o      out  1          1-cycle strobe: load TX word into shifter
//  shift_o     out  1          1-cycle strobe: advance shifter output
//  sample_o    out  1          1-cycle strobe: capture input lanes
//  sck_o       out  1          serial clock
//  cs_o        out  1          chip-select active (polarity applied downstream)
//  busy_o      out  1          transfer in progress
//  last_o      out  1          current word is the final word
// BEHAVIOUR
//  Reset values:
//  - sck_o=0 while in reset; sck_o=cpol_i after reset and whenever not in XFER.
//  - All other outputs 0; FSM in IDLE; all counters 0.
//  Divider:
//  - cnt increments each cycle in SETUP/XFER/HOLD.
//  - tick when cnt==div_i, then cnt<=0.
//  - cnt is cleared on every state entry.
//  FSM states and transitions:
//  - IDLE:  start_i & en_i -> LOAD; wcnt<=trl_i; div/cpol/cpha/mode/trl latched.
//  - LOAD:  tx_ready_o=1 iff rx_valid_o=0 (or rx_ready_i=1 same cycle).
//           tx_valid_i & tx_ready_o -> load_o pulse, goto SETUP.
//  - SETUP: one tick of CS lead -> XFER; edge counter ecnt<=0.
//  - XFER:  each tick toggles sck_o and ecnt++.
//           Edges per word = 2*bits; bits = 32/16/8 for std/dual/quad.
//           After final edge -> HOLD; rx_valid_o<=1.
//  - HOLD:  one tick of trail.
//           wcnt==0 -> IDLE.
//           else wcnt-- and -> LOAD (cs_o stays asserted).
//  Strobes (all coincide with the SCK edge cycle):
//  - CPHA=0: sample_o on leading edges; shift_o on trailing edges except the last.
//  - CPHA=1: shift_o on leading edges except the first; sample_o on trailing edges.
//  - Shifts per word = bits-1; samples per word = bits.
//  Status outputs:
//  - cs_o=1 from SETUP entry of first word until HOLD exit of last word.
//  - busy_o=1 in every state except IDLE.
//  - last_o=1 while wcnt==0 and busy_o=1.
//  RX handshake:
//  - rx_valid_o holds until rx_ready_i=1; cleared the cycle after the handshake.
//  - If rx_valid_o is still pending in LOAD, the sequencer stalls there (backpressure).
//  - SCK stays at idle level during the stall.
//  Abort:
//  - en_i=0 in any state -> IDLE next cycle.
//  - sck_o=cpol_i, cs_o=0, busy_o=0, counters cleared.
//  - No strobes; a pending rx_valid_o is dropped.
//  Config changes:
//  - Changes to config inputs while busy_o=1 are ignored; latched values are used.
//  - start_i while busy_o=1 is ignored.
// TESTING
//  T1: div=0, std, cpol0/cpha0, trl=0, tx_valid held
//      -> busy 67 cycles; 32 rising edges; 32 sample_o on rises; 31 shift_o; 1 load_o.
//  T2: div=3, quad, cpol1/cpha1, trl=1
//      -> 2 words; each 16 SCK edges of 4 cycles each.
//      -> cs_o continuous across words; last_o high only in word 2.
//  T3: trl=2, rx_ready_i=0 after word 1
//      -> stall in LOAD; tx_ready_o=0; sck_o=cpol.
//      -> rx_ready_i=1 resumes word 2 the next cycle.
//  T4: en_i dropped at edge 10 of a std word
//      -> next cycle busy_o=0, cs_o=0, sck_o=cpol; no rx_valid_o; new start_i works.
//  T5: tx_valid_i low for 5 cycles in LOAD
//      -> no SCK activity, cs_o held; transfer completes after data arrives.
//  T6: async reset mid-XFER
//      -> outputs clear immediately; after release, sck_o=cpol_i and state IDLE.

Source files
------------

// File: rtl/spi_xfer_seq.sv
// -----------------------------------------------------------------------------
// spi_xfer_seq
//   Transfer sequencer for the SPI core datapath. Divides the system clock
//   down to SCK (honouring CPOL/CPHA), counts SCK edges per word and words per
//   transfer, and issues load/shift/sample strobes to the shift register. It
//   also owns chip-select framing, busy/last status and the word-level TX/RX
//   handshakes with the register/FIFO front-end.
//
// Parameters
//   DIV_WIDTH  width of the clock divider (SCK half-period = div_i+1 clocks)
//   TRL_WIDTH  width of the transfer-length field (words per transfer - 1)
//
// Ports
//   clk_i, rst_n_i      system clock, asynchronous active-low reset
//   en_i                core enable; low aborts any transfer
//   start_i             start pulse, accepted only when idle and enabled
//   div_i, cpol_i,
//   cpha_i, mode_i,
//   trl_i               transfer configuration, latched when start is accepted
//   tx_valid_i/tx_ready_o  TX word handshake (acceptance = load_o)
//   rx_valid_o/rx_ready_i  RX word handshake
//   load_o, shift_o,
//   sample_o            one-cycle strobes to the shift register
//   sck_o, cs_o         serial clock and chip-select (active high here)
//   busy_o, last_o      transfer in progress / current word is the final one
// -----------------------------------------------------------------------------
module spi_xfer_seq #(
    parameter int DIV_WIDTH = 16,
    parameter int TRL_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 en_i,
    input  logic                 start_i,
    input  logic [DIV_WIDTH-1:0] div_i,
    input  logic                 cpol_i,
    input  logic                 cpha_i,
    input  logic [1:0]           mode_i,
    input  logic [TRL_WIDTH-1:0] trl_i,
    input  logic                 tx_valid_i,
    output logic                 tx_ready_o,
    output logic                 rx_valid_o,
    input  logic                 rx_ready_i,
    output logic                 load_o,
    output logic                 shift_o,
    output logic                 sample_o,
    output logic                 sck_o,
    output logic                 cs_o,
    output logic                 busy_o,
    output logic                 last_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETUP,
        S_XFER,
        S_HOLD
    } state_t;

    state_t               state;
    state_t               state_nx;

    logic [DIV_WIDTH-1:0] cnt;
    logic [5:0]           ecnt;
    logic [TRL_WIDTH-1:0] wcnt;
    logic                 sck_q;
    logic                 cs_q;
    logic                 rx_valid_q;

    // Latched configuration (pure data, no reset needed)
    logic [DIV_WIDTH-1:0] div_q;
    logic                 cpol_q;
    logic                 cpha_q;
    logic [1:0]           mode_q;

    logic                 timing_st;
    logic                 tick;
    logic [5:0]           last_edge;
    logic                 is_last_edge;
    logic                 edge_stb;
    logic                 leading;
    logic                 accept;
    logic                 tx_ready;
    logic                 load;
    logic                 busy;

    assign timing_st    = (state == S_SETUP) || (state == S_XFER) || (state == S_HOLD);
    assign tick         = timing_st && (cnt == div_q);
    assign is_last_edge = (ecnt == last_edge);
    assign edge_stb     = en_i && (state == S_XFER) && tick;
    // Even edge index = leading SCK edge of a bit period
    assign leading      = ~ecnt[0];
    assign accept       = (state == S_IDLE) && start_i && en_i;
    // A word may only be loaded once the previous RX word has been (or is
    // being) consumed, otherwise the shifter would overwrite it.
    assign tx_ready     = en_i && (state == S_LOAD) && (!rx_valid_q || rx_ready_i);
    assign load         = tx_ready && tx_valid_i;
    assign busy         = (state != S_IDLE);

    // Edges per word minus one: 2*bits-1 with bits = 32/16/8
    always_comb begin
        last_edge = 6'd63;
        case (mode_q)
            2'b01:   last_edge = 6'd31;
            2'b10:   last_edge = 6'd15;
            default: last_edge = 6'd63;
        endcase
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start_i) state_nx = S_LOAD;
            S_LOAD:  if (load) state_nx = S_SETUP;
            S_SETUP: if (tick) state_nx = S_XFER;
            S_XFER:  if (tick && is_last_edge) state_nx = S_HOLD;
            S_HOLD:  if (tick) state_nx = (wcnt == '0) ? S_IDLE : S_LOAD;
            default: state_nx = S_IDLE;
        endcase
        if (!en_i) state_nx = S_IDLE;
    end

    always_comb begin
        sample_o = 1'b0;
        shift_o  = 1'b0;
        if (edge_stb) begin
            if (!cpha_q) begin
                sample_o = leading;
                shift_o  = !leading && !is_last_edge;
            end else begin
                shift_o  = leading && (ecnt != 6'd0);
                sample_o = !leading;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state      <= S_IDLE;
            cnt        <= '0;
            ecnt       <= '0;
            wcnt       <= '0;
            sck_q      <= 1'b0;
            cs_q       <= 1'b0;
            rx_valid_q <= 1'b0;
        end else begin
            state <= state_nx;

            // Divider restarts on every state change so each phase is whole
            if ((state_nx != state) || !timing_st || tick) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end

            if (state_nx != S_XFER) begin
                ecnt <= '0;
            end else if (edge_stb) begin
                ecnt <= ecnt + 1'b1;
            end

            if (!en_i) begin
                wcnt <= '0;
            end else if (accept) begin
                wcnt <= trl_i;
            end else if ((state == S_HOLD) && tick && (wcnt != '0)) begin
                wcnt <= wcnt - 1'b1;
            end

            // sck_q is preloaded to the idle level before XFER is entered
            if (state != S_XFER) begin
                sck_q <= cpol_q;
            end else if (edge_stb) begin
                sck_q <= ~sck_q;
            end

            // CS rises on the first SETUP and stays up between words
            if (state_nx == S_IDLE) begin
                cs_q <= 1'b0;
            end else if (state_nx == S_SETUP) begin
                cs_q <= 1'b1;
            end

            if (!en_i) begin
                rx_valid_q <= 1'b0;
            end else if (edge_stb && is_last_edge) begin
                rx_valid_q <= 1'b1;
            end else if (rx_valid_q && rx_ready_i) begin
                rx_valid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept) begin
            div_q  <= div_i;
            cpol_q <= cpol_i;
            cpha_q <= cpha_i;
            mode_q <= mode_i;
        end
    end

    // Idle level follows the live cpol_i only while idle; during a transfer
    // (including LOAD stalls) the latched polarity is used.
    assign sck_o      = !rst_n_i ? 1'b0 :
                        (state == S_XFER) ? sck_q :
                        busy ? cpol_q : cpol_i;
    assign cs_o       = cs_q;
    assign busy_o     = busy;
    assign last_o     = busy && (wcnt == '0);
    assign rx_valid_o = rx_valid_q;
    assign tx_ready_o = tx_ready;
    assign load_o     = load;

endmodule

// File: tb/tb_spi_xfer_seq.sv
// -----------------------------------------------------------------------------
// tb_spi_xfer_seq
//   Directed self-checking bench for spi_xfer_seq: a table of whole-transfer
//   configurations with hand-computed cycle/edge/strobe counts, followed by
//   hand-written sequences for RX backpressure, abort, TX starvation with
//   config changes, and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_spi_xfer_seq;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        en_i;
    logic        start_i;
    logic [15:0] div_i;
    logic        cpol_i;
    logic        cpha_i;
    logic [1:0]  mode_i;
    logic [15:0] trl_i;
    logic        tx_valid_i;
    logic        tx_ready_o;
    logic        rx_valid_o;
    logic        rx_ready_i;
    logic        load_o;
    logic        shift_o;
    logic        sample_o;
    logic        sck_o;
    logic        cs_o;
    logic        busy_o;
    logic        last_o;

    spi_xfer_seq #(.DIV_WIDTH(16), .TRL_WIDTH(16)) dut (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .en_i       (en_i),
        .start_i    (start_i),
        .div_i      (div_i),
        .cpol_i     (cpol_i),
        .cpha_i     (cpha_i),
        .mode_i     (mode_i),
        .trl_i      (trl_i),
        .tx_valid_i (tx_valid_i),
        .tx_ready_o (tx_ready_o),
        .rx_valid_o (rx_valid_o),
        .rx_ready_i (rx_ready_i),
        .load_o     (load_o),
        .shift_o    (shift_o),
        .sample_o   (sample_o),
        .sck_o      (sck_o),
        .cs_o       (cs_o),
        .busy_o     (busy_o),
        .last_o     (last_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [15:0] div;
        logic [1:0]  mode;
        logic        cpol;
        logic        cpha;
        logic [15:0] trl;
        int          busy;
        int          toggles;
        int          samples;
        int          shifts;
        int          loads;
        int          last;
        int          cs;
    } vec_t;

    vec_t vecs [5];

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Runs one complete transfer with TX data always available and RX always
    // consumed, and compares per-transfer totals against the vector.
    task automatic run_xfer(input vec_t v, input string tag);
        int   busy_c = 0;
        int   tog = 0;
        int   smp = 0;
        int   shf = 0;
        int   ld = 0;
        int   lst = 0;
        int   csc = 0;
        int   rxc = 0;
        int   perr = 0;
        int   n = 0;
        logic prev;
        @(negedge clk_i);
        en_i       = 1'b1;
        div_i      = v.div;
        mode_i     = v.mode;
        cpol_i     = v.cpol;
        cpha_i     = v.cpha;
        trl_i      = v.trl;
        tx_valid_i = 1'b1;
        rx_ready_i = 1'b1;
        start_i    = 1'b1;
        #1;
        check({tag, " idle sck"}, int'(sck_o), int'(v.cpol));
        prev = sck_o;
        @(negedge clk_i);
        start_i = 1'b0;
        while (busy_o && n < 2000) begin
            busy_c++;
            if (sck_o != prev) tog++;
            prev = sck_o;
            smp += int'(sample_o);
            shf += int'(shift_o);
            ld  += int'(load_o);
            lst += int'(last_o);
            csc += int'(cs_o);
            rxc += int'(rx_valid_o);
            if (sample_o && (sck_o != (v.cpol ^ v.cpha))) perr++;
            if (shift_o && (sck_o != (v.cpol ^ !v.cpha))) perr++;
            @(negedge clk_i);
            n++;
        end
        check({tag, " timeout"}, int'(n >= 2000), 0);
        check({tag, " busy cycles"}, busy_c, v.busy);
        check({tag, " sck edges"}, tog, v.toggles);
        check({tag, " samples"}, smp, v.samples);
        check({tag, " shifts"}, shf, v.shifts);
        check({tag, " loads"}, ld, v.loads);
        check({tag, " rx words"}, rxc, v.loads);
        check({tag, " last cycles"}, lst, v.last);
        check({tag, " cs cycles"}, csc, v.cs);
        check({tag, " strobe phase"}, perr, 0);
    endtask

    initial begin
        int   n;
        int   tog;
        int   rem;
        int   smp;
        logic prev;

        // Per word: 1 LOAD + (div+1)*(2*bits+2); cs drops only the first LOAD
        vecs[0] = '{div:16'd0, mode:2'd0, cpol:1'b0, cpha:1'b0, trl:16'd0,
                    busy:67, toggles:64, samples:32, shifts:31, loads:1, last:67, cs:66};
        vecs[1] = '{div:16'd3, mode:2'd2, cpol:1'b1, cpha:1'b1, trl:16'd1,
                    busy:146, toggles:32, samples:16, shifts:14, loads:2, last:73, cs:145};
        vecs[2] = '{div:16'd1, mode:2'd1, cpol:1'b0, cpha:1'b1, trl:16'd0,
                    busy:69, toggles:32, samples:16, shifts:15, loads:1, last:69, cs:68};
        vecs[3] = '{div:16'd0, mode:2'd3, cpol:1'b1, cpha:1'b0, trl:16'd2,
                    busy:201, toggles:192, samples:96, shifts:93, loads:3, last:67, cs:200};
        vecs[4] = '{div:16'd2, mode:2'd2, cpol:1'b0, cpha:1'b0, trl:16'd0,
                    busy:55, toggles:16, samples:8, shifts:7, loads:1, last:55, cs:54};

        rst_n_i    = 1'b0;
        en_i       = 1'b0;
        start_i    = 1'b0;
        div_i      = '0;
        cpol_i     = 1'b1;
        cpha_i     = 1'b0;
        mode_i     = 2'd0;
        trl_i      = '0;
        tx_valid_i = 1'b0;
        rx_ready_i = 1'b0;

        // Reset state
        repeat (3) @(negedge clk_i);
        check("rst sck", int'(sck_o), 0);
        check("rst busy", int'(busy_o), 0);
        check("rst cs", int'(cs_o), 0);
        check("rst tx_ready", int'(tx_ready_o), 0);
        check("rst rx_valid", int'(rx_valid_o), 0);
        check("rst last", int'(last_o), 0);
        rst_n_i = 1'b1;
        #1;
        check("post-rst sck=cpol", int'(sck_o), 1);
        check("post-rst busy", int'(busy_o), 0);

        // Whole-transfer vectors
        for (int i = 0; i < 5; i++) begin
            run_xfer(vecs[i], $sformatf("V%0d", i));
        end

        // RX backpressure: stall in LOAD until rx_ready_i
        @(negedge clk_i);
        div_i = 16'd0; mode_i = 2'd0; cpol_i = 1'b1; cpha_i = 1'b0; trl_i = 16'd2;
        tx_valid_i = 1'b1; rx_ready_i = 1'b0; start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        n = 0;
        while (!rx_valid_o && n < 300) begin
            @(negedge clk_i);
            n++;
        end
        check("T3 word1 done", int'(n < 300), 1);
        repeat (3) @(negedge clk_i);
        check("T3 stall busy", int'(busy_o), 1);
        check("T3 stall tx_ready", int'(tx_ready_o), 0);
        check("T3 stall load", int'(load_o), 0);
        check("T3 stall sck", int'(sck_o), 1);
        check("T3 stall cs", int'(cs_o), 1);
        check("T3 stall rx_valid", int'(rx_valid_o), 1);
        check("T3 stall last", int'(last_o), 0);
        rx_ready_i = 1'b1;
        #1;
        check("T3 resume tx_ready", int'(tx_ready_o), 1);
        check("T3 resume load", int'(load_o), 1);
        @(negedge clk_i);
        check("T3 rx cleared", int'(rx_valid_o), 0);
        check("T3 cs held", int'(cs_o), 1);
        n = 0;
        while (busy_o && n < 400) begin
            @(negedge clk_i);
            n++;
        end
        check("T3 finish", int'(n < 400), 1);

        // Abort at SCK edge 10
        @(negedge clk_i);
        div_i = 16'd1; mode_i = 2'd0; cpol_i = 1'b1; cpha_i = 1'b0; trl_i = 16'd0;
        tx_valid_i = 1'b1; rx_ready_i = 1'b1; start_i = 1'b1;
        #1;
        prev = sck_o;
        @(negedge clk_i);
        start_i = 1'b0;
        tog = 0;
        n = 0;
        while (tog < 10 && n < 200) begin
            @(negedge clk_i);
            if (sck_o != prev) tog++;
            prev = sck_o;
            n++;
        end
        check("T4 reached edge 10", tog, 10);
        en_i = 1'b0;
        @(negedge clk_i);
        check("T4 busy", int'(busy_o), 0);
        check("T4 cs", int'(cs_o), 0);
        check("T4 sck", int'(sck_o), 1);
        check("T4 strobes", int'(sample_o | shift_o | load_o), 0);
        repeat (3) @(negedge clk_i);
        check("T4 no rx_valid", int'(rx_valid_o), 0);
        check("T4 last", int'(last_o), 0);
        run_xfer(vecs[0], "T4 restart");

        // TX starvation in LOAD plus ignored config / start changes
        @(negedge clk_i);
        div_i = 16'd0; mode_i = 2'd0; cpol_i = 1'b0; cpha_i = 1'b1; trl_i = 16'd0;
        tx_valid_i = 1'b0; rx_ready_i = 1'b1; start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        cpol_i = 1'b1; div_i = 16'd7; mode_i = 2'd2;
        for (int k = 0; k < 5; k++) begin
            check("T5 wait busy", int'(busy_o), 1);
            check("T5 wait load", int'(load_o), 0);
            check("T5 wait sck", int'(sck_o), 0);
            check("T5 wait cs", int'(cs_o), 0);
            @(negedge clk_i);
        end
        tx_valid_i = 1'b1;
        #1;
        check("T5 load", int'(load_o), 1);
        @(negedge clk_i);
        rem = 0;
        smp = 0;
        while (busy_o && rem < 500) begin
            smp += int'(sample_o);
            if (rem == 10) start_i = 1'b1;
            if (rem == 11) start_i = 1'b0;
            @(negedge clk_i);
            rem++;
        end
        start_i = 1'b0;
        check("T5 remaining cycles", rem, 66);
        check("T5 samples", smp, 32);
        repeat (2) @(negedge clk_i);
        check("T5 no restart", int'(busy_o), 0);
        check("T5 idle sck live cpol", int'(sck_o), 1);

        // Asynchronous reset mid-XFER
        @(negedge clk_i);
        div_i = 16'd0; mode_i = 2'd0; cpol_i = 1'b1; cpha_i = 1'b0; trl_i = 16'd0;
        tx_valid_i = 1'b1; rx_ready_i = 1'b1; start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (20) @(negedge clk_i);
        check("T6 in xfer", int'(busy_o & cs_o), 1);
        #2;
        rst_n_i = 1'b0;
        #1;
        check("T6 busy", int'(busy_o), 0);
        check("T6 cs", int'(cs_o), 0);
        check("T6 sck", int'(sck_o), 0);
        check("T6 strobes", int'(sample_o | shift_o | load_o | tx_ready_o), 0);
        check("T6 rx_valid", int'(rx_valid_o), 0);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        #1;
        check("T6 post sck", int'(sck_o), 1);
        check("T6 post busy", int'(busy_o), 0);
        repeat (3) @(negedge clk_i);
        check("T6 stays idle", int'(busy_o), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
